// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory and
// captures the fetched word into the IF/ID register.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_taken,
    input  logic [31:0] exc_target,
    input  logic        exc_use_vec,
    output logic        inst_ce,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_data,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        id_adel
);

    logic [31:0] r_pc;
    logic        r_ce;
    logic        r_pend_valid;
    logic [31:0] r_pend_target;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_inst;
    logic        r_id_valid;
    logic        r_id_adel;

    logic        w_adel;
    logic [31:0] w_exc_pc;

    assign w_adel   = (r_pc[1:0] != 2'b00);
    assign w_exc_pc = exc_use_vec ? EXC_VECTOR : exc_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_ce          <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'h0;
            r_id_pc       <= 32'h0;
            r_id_inst     <= 32'h0;
            r_id_valid    <= 1'b0;
            r_id_adel     <= 1'b0;
        end else begin
            r_ce <= 1'b1;
            if (!r_ce) begin
                r_id_pc    <= 32'h0;
                r_id_inst  <= 32'h0;
                r_id_valid <= 1'b0;
                r_id_adel  <= 1'b0;
            end else if (exc_taken) begin
                r_pc         <= w_exc_pc;
                r_pend_valid <= 1'b0;
                r_id_pc      <= 32'h0;
                r_id_inst    <= 32'h0;
                r_id_valid   <= 1'b0;
                r_id_adel    <= 1'b0;
            end else if (stall) begin
                // Remember a redirect resolved during a stall; the delay slot
                // is still sitting in IF and is captured when the stall drops.
                if (br_taken) begin
                    r_pend_target <= br_target;
                    r_pend_valid  <= 1'b1;
                end
            end else begin
                r_id_pc    <= r_pc;
                r_id_inst  <= w_adel ? 32'h0 : inst_data;
                r_id_valid <= 1'b1;
                r_id_adel  <= w_adel;
                if (br_taken) begin
                    r_pc         <= br_target;
                    r_pend_valid <= 1'b0;
                end else if (r_pend_valid) begin
                    r_pc         <= r_pend_target;
                    r_pend_valid <= 1'b0;
                end else begin
                    r_pc <= r_pc + 32'd4;
                end
            end
        end
    end

    assign inst_ce   = r_ce;
    assign inst_addr = r_pc;
    assign id_pc     = r_id_pc;
    assign id_inst   = r_id_inst;
    assign id_valid  = r_id_valid;
    assign id_adel   = r_id_adel;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline. It sits directly upstream of the instruction memory.
- Owns the PC and drives the memory's chip-enable and byte address. The memory returns the instruction combinationally in the same cycle.
- Captures the returned word into the IF/ID pipeline register.
- Handles pipeline stall, branch/jump redirect (MIPS one-slot delay semantics) and exception redirect with flush.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- EXC_VECTOR, 32'h0000_0040, fetch address taken on exception redirect.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID contents.
- br_taken  in  1  ID stage: branch/jump resolved taken this cycle.
- br_target  in  32  redirect address accompanying br_taken.
- exc_taken  in  1  exception/eret redirect; flushes IF/ID.
- exc_target  in  32  redirect address for eret; EXC_VECTOR is used when exc_use_vec=1.
- exc_use_vec  in  1  select EXC_VECTOR (1) or exc_target (0).
- inst_ce  out  1  chip-enable to instruction memory.
- inst_addr  out  32  byte address to instruction memory (= pc).
- inst_data  in  32  instruction word from memory, combinational.
- id_pc  out  32  PC of instruction held in IF/ID.
- id_inst  out  32  instruction held in IF/ID.
- id_valid  out  1  IF/ID holds a real instruction.
- id_adel  out  1  IF/ID entry raised a fetch address error (pc[1:0] != 0).

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, inst_ce=0, pend_valid=0.
  - id_pc=0, id_inst=0, id_valid=0, id_adel=0.
- inst_ce is a register. It goes to 1 on the first rising edge after rst deasserts and stays 1 until the next reset.
- While inst_ce=0, pc does not advance and the IF/ID register loads a bubble.
- inst_addr = pc at all times (combinational from the register).
- Next-PC priority, evaluated each rising edge while inst_ce=1:
  1. exc_taken: pc = exc_use_vec ? EXC_VECTOR : exc_target. Overrides stall. IF/ID loads a bubble (valid=0, inst=0, adel=0). pend_valid is cleared.
  2. stall=1: pc and IF/ID hold. If br_taken=1, latch br_target into pend_target and set pend_valid=1; a later br_taken while pending overwrites it.
  3. br_taken=1: pc = br_target. The word fetched this cycle (the delay slot) is captured normally into IF/ID.
  4. pend_valid=1: pc = pend_target and pend_valid is cleared. The current word is captured normally.
  5. Otherwise: pc = pc + 4, 32-bit wrap-around (32'hFFFF_FFFC -> 0).
- IF/ID capture when no stall and no exception:
  - id_pc = pc, id_valid = 1, id_adel = (pc[1:0] != 0).
  - id_inst = inst_data, or 0 when adel.
  - The misaligned PC still advances per the priority above; downstream raises the exception.
- Latency: instruction at address A appears on id_inst one clock after pc=A with no stall. The redirect target is fetched the cycle after br_taken.
- stall and br_taken in the same cycle must not lose the redirect. The delay slot is already in IF during that cycle and is captured when stall drops, together with the jump to pend_target.
- Reset asserted mid-operation aborts everything, including any pending redirect; state returns to the reset values asynchronously.

Test Plan:
- Reset release:
  - Stimulus: assert rst, release, leave it free-running.
  - Required: inst_ce rises one edge later. inst_addr runs 0, 4, 8, C. id_inst sequence equals mem[0..3], e.g. 32'h0000f025, 32'h241d1000. id_valid goes to 1 exactly one edge after inst_ce.
- Taken branch with delay slot:
  - Stimulus: at pc=0x0C, pulse br_taken with br_target=0x40.
  - Required: IF/ID gets the word at 0x0C (delay slot) with id_pc=0x0C. The next id_pc is 0x40 and then 0x44.
- Stall with branch:
  - Stimulus: pc=0x10, stall=1 for 3 cycles, br_taken with br_target=0x30 in the first stall cycle.
  - Required: pc stays 0x10 and IF/ID holds during the stall. After release, IF/ID captures pc 0x10, then id_pc=0x30.
- Exception during stall:
  - Stimulus: stall=1 and exc_taken=1 with exc_use_vec=1.
  - Required: next pc=0x40 and id_valid=0 next cycle. Any pending branch is discarded.
- Misaligned redirect:
  - Stimulus: br_target=0x22.
  - Required: the entry with id_pc=0x22 has id_adel=1 and id_inst=0. The following pc is 0x26.
- Async reset mid-run:
  - Stimulus: assert rst between edges while pend_valid=1.
  - Required: pc=0, inst_ce=0 and id_valid=0 immediately without waiting for a clock. After release, fetch restarts at 0 with no redirect.
